// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and the parity rule
// used by both ends of the link.
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START_BIT,
      S_DATA_BITS,
      S_PARITY_BIT,
      S_STOP_BIT1,
      S_STOP_BIT2,
      S_BREAK
   } uart_tx_state_t;

   // Narrower frames are zero-extended, which leaves the parity unchanged.
   function automatic logic calc_parity(input logic [7:0] data, input logic parity_type);
      return parity_type ? ~^data : ^data;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO with extra-MSB pointers; read data is the
// combinational head entry.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [AW:0]      wr_ptr, rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             push_ok, pop_ok;

   // A push into a full FIFO is only taken when the head leaves in the same cycle.
   assign push_ok = push && (!full || pop);
   assign pop_ok  = pop && !empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
   end

   assign dout  = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-fed serialiser on the shared 16x tick, with parity,
// one or two stop bits, CTS gating at frame start and break generation.
module uart_tx
   import uart_pkg::*;
#(
   parameter int       DATA_BITS   = 8,
   parameter logic     PARITY_EN   = 1'b1,
   parameter logic     PARITY_TYPE = 1'b0,
   parameter int       STOP_BITS   = 1,
   parameter int       FIFO_DEPTH  = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          tick_16x,
   input  logic [DATA_BITS-1:0]          tx_data,
   input  logic                          write_data,
   input  logic                          cts,
   input  logic                          send_break,
   input  logic                          clear_error,
   output logic                          tx_out,
   output logic                          tx_busy,
   output logic                          tx_done,
   output logic                          tx_fifo_full,
   output logic                          tx_fifo_empty,
   output logic [$clog2(FIFO_DEPTH):0]   tx_fifo_level,
   output logic                          overflow_error
);

   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   uart_tx_state_t       state, state_next;
   logic [3:0]           sample_cnt, cnt_next;
   logic [2:0]           bit_cnt, bit_next;
   logic [DATA_BITS-1:0] shift_reg, shift_next;
   logic                 parity_bit, par_next;
   logic                 recovery, rec_next;
   logic                 done_next, line_next;
   logic                 pop, load, frame_end, can_start;
   logic [DATA_BITS-1:0] fifo_dout;

   // write_data is an unconditional push: there is no ready, a push into a
   // full FIFO is dropped and flagged through overflow_error.
   uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (write_data),
      .pop   (pop),
      .din   (tx_data),
      .dout  (fifo_dout),
      .full  (tx_fifo_full),
      .empty (tx_fifo_empty),
      .level (tx_fifo_level)
   );

   assign can_start = !tx_fifo_empty && cts && !send_break;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         sample_cnt     <= '0;
         bit_cnt        <= '0;
         shift_reg      <= '0;
         parity_bit     <= 1'b0;
         recovery       <= 1'b0;
         tx_out         <= 1'b1;
         tx_done        <= 1'b0;
         overflow_error <= 1'b0;
      end else begin
         state      <= state_next;
         sample_cnt <= cnt_next;
         bit_cnt    <= bit_next;
         shift_reg  <= shift_next;
         parity_bit <= par_next;
         recovery   <= rec_next;
         tx_out     <= line_next;
         tx_done    <= done_next;
         if (write_data && tx_fifo_full && !pop) overflow_error <= 1'b1;
         else if (clear_error)                   overflow_error <= 1'b0;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = sample_cnt;
      bit_next   = bit_cnt;
      shift_next = shift_reg;
      par_next   = parity_bit;
      rec_next   = recovery;
      done_next  = 1'b0;
      pop        = 1'b0;
      load       = 1'b0;
      frame_end  = 1'b0;
      line_next  = 1'b1;
      if (tick_16x) begin
         case (state)
            S_IDLE: begin
               cnt_next = '0;
               if (send_break) state_next = S_BREAK;
               else            load       = can_start;
            end
            S_BREAK: begin
               if (!send_break) begin
                  state_next = S_STOP_BIT1;
                  rec_next   = 1'b1;
                  cnt_next   = '0;
               end
            end
            default: begin
               if (sample_cnt == 4'd15) begin
                  cnt_next = '0;
                  case (state)
                     S_START_BIT: begin
                        state_next = S_DATA_BITS;
                        bit_next   = '0;
                     end
                     S_DATA_BITS: begin
                        if (bit_cnt == LAST_BIT) begin
                           state_next = PARITY_EN ? S_PARITY_BIT : S_STOP_BIT1;
                        end else begin
                           bit_next   = bit_cnt + 3'd1;
                           shift_next = shift_reg >> 1;
                        end
                     end
                     S_PARITY_BIT: state_next = S_STOP_BIT1;
                     S_STOP_BIT1: begin
                        if (STOP_BITS == 2) state_next = S_STOP_BIT2;
                        else                frame_end  = 1'b1;
                     end
                     default: frame_end = 1'b1;
                  endcase
               end else begin
                  cnt_next = sample_cnt + 4'd1;
               end
            end
         endcase
         // The last stop tick may launch the next start bit directly so that
         // queued frames leave with no idle gap.
         if (frame_end) begin
            done_next  = !recovery;
            rec_next   = 1'b0;
            state_next = S_IDLE;
            load       = can_start;
         end
         if (load) begin
            pop        = 1'b1;
            shift_next = fifo_dout;
            par_next   = calc_parity(8'(fifo_dout), PARITY_TYPE);
            bit_next   = '0;
            cnt_next   = '0;
            state_next = S_START_BIT;
         end
      end
      case (state_next)
         S_START_BIT:  line_next = 1'b0;
         S_DATA_BITS:  line_next = shift_next[0];
         S_PARITY_BIT: line_next = par_next;
         S_BREAK:      line_next = 1'b0;
         default:      line_next = 1'b1;
      endcase
   end

   assign tx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: an 8E1 instance and an 8O2 instance share the
// clock, reset and a 16x tick that fires every third clock.
module tb_uart_tx;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tick_16x = 1'b0;
   int   tick_div = 0;

   logic [7:0] tx_data = '0;
   logic       write_data = 1'b0, cts = 1'b0, send_break = 1'b0, clear_error = 1'b0;
   logic       tx_out, tx_busy, tx_done, tx_fifo_full, tx_fifo_empty, overflow_error;
   logic [3:0] tx_fifo_level;

   logic [7:0] tx_data2 = '0;
   logic       write2 = 1'b0, cts2 = 1'b1, send_break2 = 1'b0, clear_error2 = 1'b0;
   logic       tx_out2, tx_busy2, tx_done2, tx_fifo_full2, tx_fifo_empty2, overflow_error2;
   logic [3:0] tx_fifo_level2;

   int n_vec = 0;
   int n_err = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   always @(negedge clk) begin
      tick_div = (tick_div == 2) ? 0 : tick_div + 1;
      tick_16x = (tick_div == 0);
   end

   always @(posedge clk) if (tx_done === 1'b1) done_cnt <= done_cnt + 1;

   uart_tx dut (
      .clk(clk), .rst(rst), .tick_16x(tick_16x), .tx_data(tx_data),
      .write_data(write_data), .cts(cts), .send_break(send_break),
      .clear_error(clear_error), .tx_out(tx_out), .tx_busy(tx_busy),
      .tx_done(tx_done), .tx_fifo_full(tx_fifo_full), .tx_fifo_empty(tx_fifo_empty),
      .tx_fifo_level(tx_fifo_level), .overflow_error(overflow_error)
   );

   uart_tx #(.PARITY_TYPE(1'b1), .STOP_BITS(2)) dut2 (
      .clk(clk), .rst(rst), .tick_16x(tick_16x), .tx_data(tx_data2),
      .write_data(write2), .cts(cts2), .send_break(send_break2),
      .clear_error(clear_error2), .tx_out(tx_out2), .tx_busy(tx_busy2),
      .tx_done(tx_done2), .tx_fifo_full(tx_fifo_full2), .tx_fifo_empty(tx_fifo_empty2),
      .tx_fifo_level(tx_fifo_level2), .overflow_error(overflow_error2)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Frame bits LSB first: start, 8 data, parity, then stop bits.
   function automatic logic [11:0] frame_bits(input logic [7:0] d, input logic odd);
      logic [11:0] f;
      f      = '1;
      f[0]   = 1'b0;
      f[8:1] = d;
      f[9]   = odd ? ~(^d) : ^d;
      return f;
   endfunction

   task automatic next_tick();
      do begin
         @(posedge clk);
         #1;
      end while (!tick_16x);
   endtask

   task automatic push(input bit sel, input logic [7:0] d, input logic clr);
      @(negedge clk);
      if (sel) begin
         tx_data2 = d;
         write2   = 1'b1;
      end else begin
         tx_data     = d;
         write_data  = 1'b1;
         clear_error = clr;
      end
      @(negedge clk);
      write_data  = 1'b0;
      write2      = 1'b0;
      clear_error = 1'b0;
   endtask

   task automatic wait_start(input bit sel, input string name);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 3000 && !found; i++) begin
         @(posedge clk);
         #1;
         if ((sel ? tx_out2 : tx_out) === 1'b0) found = 1'b1;
      end
      n_vec++;
      if (!found || tick_16x !== 1'b1) begin
         n_err++;
         $display("FAIL %s start: found=%0b on_tick=%0b, required found=1 on_tick=1",
                  name, found, tick_16x);
      end
   endtask

   task automatic check_frame(input bit sel, input logic [11:0] bits, input int nb,
                              input string name);
      logic bad, act, line;
      for (int b = 0; b < nb; b++) begin
         bad = 1'b0;
         act = bits[b];
         for (int s = 0; s < 16; s++) begin
            if (b != 0 || s != 0) next_tick();
            line = sel ? tx_out2 : tx_out;
            if (line !== bits[b]) begin
               bad = 1'b1;
               act = line;
            end
         end
         n_vec++;
         if (bad) begin
            n_err++;
            $display("FAIL %s bit %0d: line %b, required %b for 16 ticks",
                     name, b, act, bits[b]);
         end
      end
   endtask

   task automatic check_end(input bit sel, input string name, input logic exp_line);
      logic d, l;
      next_tick();
      d = sel ? tx_done2 : tx_done;
      l = sel ? tx_out2 : tx_out;
      n_vec++;
      if (d !== 1'b1 || l !== exp_line) begin
         n_err++;
         $display("FAIL %s end: tx_done=%b tx_out=%b, required tx_done=1 tx_out=%b",
                  name, d, l, exp_line);
      end
      @(posedge clk);
      #1;
      d = sel ? tx_done2 : tx_done;
      n_vec++;
      if (d !== 1'b0) begin
         n_err++;
         $display("FAIL %s done_width: tx_done=%b a cycle later, required 0", name, d);
      end
   endtask

   task automatic hold_line(input int nt, input logic exp, input string name);
      logic bad, act;
      bad = 1'b0;
      act = exp;
      for (int k = 0; k < nt; k++) begin
         next_tick();
         if (tx_out !== exp) begin
            bad = 1'b1;
            act = tx_out;
         end
      end
      n_vec++;
      if (bad) begin
         n_err++;
         $display("FAIL %s hold: tx_out=%b, required %b for %0d ticks", name, act, exp, nt);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_vec += 7;
      if (tx_out !== 1'b1)         begin n_err++; $display("FAIL reset tx_out: %b, required 1", tx_out); end
      if (tx_busy !== 1'b0)        begin n_err++; $display("FAIL reset tx_busy: %b, required 0", tx_busy); end
      if (tx_done !== 1'b0)        begin n_err++; $display("FAIL reset tx_done: %b, required 0", tx_done); end
      if (tx_fifo_empty !== 1'b1)  begin n_err++; $display("FAIL reset empty: %b, required 1", tx_fifo_empty); end
      if (tx_fifo_full !== 1'b0)   begin n_err++; $display("FAIL reset full: %b, required 0", tx_fifo_full); end
      if (tx_fifo_level !== 4'd0)  begin n_err++; $display("FAIL reset level: %0d, required 0", tx_fifo_level); end
      if (overflow_error !== 1'b0) begin n_err++; $display("FAIL reset overflow: %b, required 0", overflow_error); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic_frame();
      cts = 1'b1;
      push(1'b0, 8'hA5, 1'b0);
      wait_start(1'b0, "basic");
      check_frame(1'b0, frame_bits(8'hA5, 1'b0), 11, "basic");
      check_end(1'b0, "basic", 1'b1);
      n_vec++;
      if (tx_busy !== 1'b0) begin n_err++; $display("FAIL basic busy: %b, required 0", tx_busy); end
   endtask

   task automatic test_odd_two_stop();
      push(1'b1, 8'h00, 1'b0);
      wait_start(1'b1, "odd2");
      check_frame(1'b1, frame_bits(8'h00, 1'b1), 12, "odd2");
      check_end(1'b1, "odd2", 1'b1);
   endtask

   task automatic test_overflow_back_to_back();
      logic [7:0] vals [8];
      vals = '{8'h01, 8'h80, 8'hFF, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h3C};
      cts = 1'b0;
      for (int i = 0; i < 8; i++) begin
         push(1'b0, vals[i], 1'b0);
         if (i == 0) begin
            n_vec++;
            if (tx_fifo_level !== 4'd1 || tx_fifo_empty !== 1'b0) begin
               n_err++;
               $display("FAIL fill first: level=%0d empty=%b, required 1 0", tx_fifo_level, tx_fifo_empty);
            end
         end
      end
      n_vec++;
      if (tx_fifo_full !== 1'b1 || tx_fifo_level !== 4'd8 || overflow_error !== 1'b0) begin
         n_err++;
         $display("FAIL fill full: full=%b level=%0d ovf=%b, required 1 8 0",
                  tx_fifo_full, tx_fifo_level, overflow_error);
      end
      push(1'b0, 8'h99, 1'b1);
      n_vec++;
      if (overflow_error !== 1'b1 || tx_fifo_level !== 4'd8) begin
         n_err++;
         $display("FAIL overflow set: ovf=%b level=%0d, required 1 8", overflow_error, tx_fifo_level);
      end
      cts = 1'b1;
      wait_start(1'b0, "b2b");
      for (int i = 0; i < 8; i++) begin
         check_frame(1'b0, frame_bits(vals[i], 1'b0), 11, $sformatf("b2b%0d", i));
         check_end(1'b0, $sformatf("b2b%0d", i), (i == 7) ? 1'b1 : 1'b0);
      end
      n_vec++;
      if (tx_busy !== 1'b0 || tx_fifo_empty !== 1'b1) begin
         n_err++;
         $display("FAIL b2b drain: busy=%b empty=%b, required 0 1", tx_busy, tx_fifo_empty);
      end
      hold_line(40, 1'b1, "lost9th");
      n_vec++;
      if (overflow_error !== 1'b1) begin n_err++; $display("FAIL overflow sticky: %b, required 1", overflow_error); end
      @(negedge clk);
      clear_error = 1'b1;
      @(negedge clk);
      clear_error = 1'b0;
      n_vec++;
      if (overflow_error !== 1'b0) begin n_err++; $display("FAIL overflow clear: %b, required 0", overflow_error); end
   endtask

   task automatic test_cts_mid_frame();
      cts = 1'b0;
      push(1'b0, 8'h81, 1'b0);
      push(1'b0, 8'h42, 1'b0);
      cts = 1'b1;
      wait_start(1'b0, "cts");
      cts = 1'b0;
      check_frame(1'b0, frame_bits(8'h81, 1'b0), 11, "cts");
      check_end(1'b0, "cts", 1'b1);
      hold_line(40, 1'b1, "cts_idle");
      n_vec++;
      if (tx_busy !== 1'b0 || tx_fifo_level !== 4'd1) begin
         n_err++;
         $display("FAIL cts wait: busy=%b level=%0d, required 0 1", tx_busy, tx_fifo_level);
      end
      cts = 1'b1;
      next_tick();
      n_vec++;
      if (tx_out !== 1'b0) begin n_err++; $display("FAIL cts resume: tx_out=%b, required 0", tx_out); end
      check_frame(1'b0, frame_bits(8'h42, 1'b0), 11, "cts2");
      check_end(1'b0, "cts2", 1'b1);
   endtask

   task automatic test_break();
      int d0;
      cts = 1'b0;
      push(1'b0, 8'h3C, 1'b0);
      push(1'b0, 8'hC3, 1'b0);
      cts = 1'b1;
      wait_start(1'b0, "brk");
      send_break = 1'b1;
      check_frame(1'b0, frame_bits(8'h3C, 1'b0), 11, "brk");
      check_end(1'b0, "brk", 1'b1);
      hold_line(41, 1'b0, "break_low");
      d0 = done_cnt;
      send_break = 1'b0;
      hold_line(16, 1'b1, "break_mark");
      next_tick();
      n_vec++;
      if (tx_out !== 1'b0 || done_cnt !== d0) begin
         n_err++;
         $display("FAIL break recovery: tx_out=%b done_pulses=%0d, required 0 %0d", tx_out, done_cnt, d0);
      end
      check_frame(1'b0, frame_bits(8'hC3, 1'b0), 11, "brk2");
      check_end(1'b0, "brk2", 1'b1);
   endtask

   task automatic test_reset_mid_frame();
      cts = 1'b0;
      push(1'b0, 8'h5A, 1'b0);
      push(1'b0, 8'h11, 1'b0);
      cts = 1'b1;
      wait_start(1'b0, "rstmid");
      repeat (70) next_tick();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_vec++;
      if (tx_out !== 1'b1 || tx_fifo_empty !== 1'b1 || tx_busy !== 1'b0 || tx_fifo_level !== 4'd0) begin
         n_err++;
         $display("FAIL reset mid: tx_out=%b empty=%b busy=%b level=%0d, required 1 1 0 0",
                  tx_out, tx_fifo_empty, tx_busy, tx_fifo_level);
      end
      @(negedge clk);
      rst = 1'b0;
      hold_line(40, 1'b1, "rst_discard");
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_odd_two_stop();
      test_overflow_back_to_back();
      test_cts_mid_frame();
      test_break();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
